// File: rtl/fft_pkg.sv
// Shared types, sizes and helpers for the FFT control sequencer.
// Bit reversal is a plain function so both the RTL and any wrapper can reuse it.
package fft_pkg;

   localparam int FFT_N      = 64;
   localparam int FFT_LOG2_N = 6;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      DRAIN,
      DONE
   } fft_seq_state_t;

   // Reverses the low 'width' bits of value; bits above width come back zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] v;
      logic [31:0] r;
      v = value;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth delay line that turns butterfly issue strobes and pair
// addresses into write-back strobes once the butterfly result is valid.
module fft_wb_delay
   import fft_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = FFT_LOG2_N
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         issue,
   input  logic [W-1:0] addr_a,
   input  logic [W-1:0] addr_b,
   output logic         wb_en,
   output logic [W-1:0] wb_addr_a,
   output logic [W-1:0] wb_addr_b
);

   localparam int EW = 2 * W + 1;

   logic [DEPTH-1:0][EW-1:0] pipe;

   // Free-running shift: hold never stalls it, so bubbles arrive as wb_en=0.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= {issue, addr_a, addr_b};
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign {wb_en, wb_addr_a, wb_addr_b} = pipe[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// Radix-2 DIT FFT control sequencer: load, butterfly issue per stage, drain, done.
// Define FFT_SEQ_BITREV_EN to scatter loaded samples to bit-reversed registers.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int N      = FFT_N,
   parameter int LOG2_N = FFT_LOG2_N,
   parameter int BF_LAT = 2
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              load_en,
   output logic [LOG2_N-1:0] load_src,
   output logic [LOG2_N-1:0] load_addr,
   output logic              bf_issue,
   output logic [LOG2_N-1:0] stage,
   output logic [LOG2_N-1:0] addr_a,
   output logic [LOG2_N-1:0] addr_b,
   output logic [LOG2_N-2:0] tw_idx,
   output logic              wb_en,
   output logic [LOG2_N-1:0] wb_addr_a,
   output logic [LOG2_N-1:0] wb_addr_b
);

   localparam int KW = LOG2_N - 1;
   localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

   fft_seq_state_t    state, state_nxt;
   logic [LOG2_N-1:0] load_cnt, load_nxt;
   logic [LOG2_N-1:0] stage_cnt, stage_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [DW-1:0]     drain_cnt, drain_nxt;

   logic [KW-1:0]     pos;
   logic [LOG2_N-1:0] pair_a, pair_b;
   logic [KW-1:0]     tw;

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         load_cnt  <= '0;
         stage_cnt <= '0;
         k         <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         load_cnt  <= load_nxt;
         stage_cnt <= stage_nxt;
         k         <= k_nxt;
         drain_cnt <= drain_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_nxt  = load_cnt;
      stage_nxt = stage_cnt;
      k_nxt     = k;
      drain_nxt = drain_cnt;
      busy      = (state != IDLE);
      done      = (state == DONE);
      load_en   = 1'b0;
      bf_issue  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               load_nxt  = '0;
               stage_nxt = '0;
               k_nxt     = '0;
               drain_nxt = '0;
            end
         end
         LOAD: begin
            load_en = 1'b1;
            if (load_cnt == LOG2_N'(N - 1)) begin
               state_nxt = ISSUE;
               stage_nxt = '0;
               k_nxt     = '0;
            end else begin
               load_nxt = load_cnt + LOG2_N'(1);
            end
         end
         ISSUE: begin
            bf_issue = ~hold;
            if (!hold) begin
               if (k == KW'(N / 2 - 1)) begin
                  state_nxt = DRAIN;
                  drain_nxt = '0;
               end else begin
                  k_nxt = k + KW'(1);
               end
            end
         end
         DRAIN: begin
            // The last write of this stage must land before the next stage reads.
            if (drain_cnt == DW'(BF_LAT - 1)) begin
               if (stage_cnt == LOG2_N'(LOG2_N - 1)) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ISSUE;
                  stage_nxt = stage_cnt + LOG2_N'(1);
                  k_nxt     = '0;
               end
            end else begin
               drain_nxt = drain_cnt + DW'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Butterfly k of a stage pairs registers half apart inside blocks of 2*half.
   always_comb begin
      pos    = k & KW'((32'd1 << stage_cnt) - 32'd1);
      pair_a = (({1'b0, k} >> stage_cnt) << (stage_cnt + LOG2_N'(1))) | {1'b0, pos};
      pair_b = pair_a + LOG2_N'(32'd1 << stage_cnt);
      tw     = pos << (LOG2_N'(LOG2_N - 1) - stage_cnt);
   end

   assign stage    = stage_cnt;
   assign addr_a   = (state == ISSUE) ? pair_a : '0;
   assign addr_b   = (state == ISSUE) ? pair_b : '0;
   assign tw_idx   = (state == ISSUE) ? tw : '0;
   assign load_src = load_en ? load_cnt : '0;

`ifdef FFT_SEQ_BITREV_EN
   assign load_addr = load_en ? LOG2_N'(bitrev(32'(load_cnt), LOG2_N)) : '0;
`else
   assign load_addr = load_en ? load_cnt : '0;
`endif

   fft_wb_delay #(
      .DEPTH (BF_LAT),
      .W     (LOG2_N)
   ) u_wb_delay (
      .clk       (clk),
      .rst       (rst),
      .issue     (bf_issue),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .wb_en     (wb_en),
      .wb_addr_a (wb_addr_a),
      .wb_addr_b (wb_addr_b)
   );

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: expected per-cycle traces are built
// from the FFT schedule (load list, butterfly list per stage, drain, done).
module tb_fft_sequencer;

   localparam int N      = 64;
   localparam int LOG2_N = 6;
   localparam int BF_LAT = 2;
   localparam int HALF_N = N / 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              hold;
   logic              busy;
   logic              done;
   logic              load_en;
   logic [LOG2_N-1:0] load_src;
   logic [LOG2_N-1:0] load_addr;
   logic              bf_issue;
   logic [LOG2_N-1:0] stage;
   logic [LOG2_N-1:0] addr_a;
   logic [LOG2_N-1:0] addr_b;
   logic [LOG2_N-2:0] tw_idx;
   logic              wb_en;
   logic [LOG2_N-1:0] wb_addr_a;
   logic [LOG2_N-1:0] wb_addr_b;

   typedef struct {
      logic start;
      logic hold;
      logic busy;
      logic done;
      logic load_en;
      logic bf_issue;
      int   load_src;
      int   load_addr;
      int   stage;
      int   k;
      int   addr_a;
      int   addr_b;
      int   tw;
   } vec_t;

   typedef struct {
      int s;
      int k;
      int a;
      int b;
      int tw;
   } bf_vec_t;

   vec_t    trace[$];
   bf_vec_t known[6];
   int      known_load[4];
   int      checks = 0;
   int      errors = 0;
   int      hold_total;
   int      obs_a[LOG2_N*HALF_N];
   int      obs_b[LOG2_N*HALF_N];
   int      obs_tw[LOG2_N*HALF_N];
   int      obs_load[N];

   fft_sequencer #(
      .N      (N),
      .LOG2_N (LOG2_N),
      .BF_LAT (BF_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hold      (hold),
      .busy      (busy),
      .done      (done),
      .load_en   (load_en),
      .load_src  (load_src),
      .load_addr (load_addr),
      .bf_issue  (bf_issue),
      .stage     (stage),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .tw_idx    (tw_idx),
      .wb_en     (wb_en),
      .wb_addr_a (wb_addr_a),
      .wb_addr_b (wb_addr_b)
   );

   // Design flops move on the falling edge; the bench drives and samples on the rising one.
   always #5 clk = ~clk;

   function automatic int ref_bitrev(input int v, input int bits);
      int r;
      int x;
      r = 0;
      x = v;
      for (int i = 0; i < bits; i++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   function automatic vec_t blank_vec();
      vec_t r;
      r.start     = 1'b0;
      r.hold      = 1'b0;
      r.busy      = 1'b0;
      r.done      = 1'b0;
      r.load_en   = 1'b0;
      r.bf_issue  = 1'b0;
      r.load_src  = 0;
      r.load_addr = 0;
      r.stage     = -1;
      r.k         = 0;
      r.addr_a    = 0;
      r.addr_b    = 0;
      r.tw        = 0;
      return r;
   endfunction

   function automatic logic pick_start(input int mode);
      return (mode == 2) && ($urandom_range(0, 9) == 0);
   endfunction

   task automatic apply_stimulus(input logic s, input logic h);
      @(posedge clk);
      start = s;
      hold  = h;
      #1;
   endtask

   task automatic check_output(input string name, input int idx,
                               input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d got %0h want %0h", name, idx, got, want);
      end
   endtask

   task automatic check_reset_values(input string name);
      check_output({name, " ctrl"}, 0,
                   {27'b0, busy, done, load_en, bf_issue, wb_en}, 32'h0);
      check_output({name, " idx"}, 0,
                   {2'b0, load_src, load_addr, stage, addr_a, addr_b}, 32'h0);
      check_output({name, " tw/wb"}, 0,
                   {15'b0, tw_idx, wb_addr_a, wb_addr_b}, 32'h0);
   endtask

   // Builds the expected cycle-by-cycle schedule of one transform.
   // mode 0: no hold; mode 1: 5 holds in stage 2 plus stray starts; mode 2: random.
   task automatic build_trace(input int mode);
      vec_t r;
      int   nh;
      int   half;
      trace.delete();
      hold_total = 0;
      for (int i = 0; i < N; i++) begin
         r           = blank_vec();
         r.busy      = 1'b1;
         r.load_en   = 1'b1;
         r.load_src  = i;
`ifdef FFT_SEQ_BITREV_EN
         r.load_addr = ref_bitrev(i, LOG2_N);
`else
         r.load_addr = i;
`endif
         r.hold      = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         r.start     = pick_start(mode) || (mode == 1 && i == 10);
         trace.push_back(r);
      end
      for (int s = 0; s < LOG2_N; s++) begin
         half = 1;
         for (int j = 0; j < s; j++) half = half * 2;
         for (int k = 0; k < HALF_N; k++) begin
            if (mode == 1 && s == 2 && k == 3) nh = 5;
            else if (mode == 2 && $urandom_range(0, 4) == 0) nh = int'($urandom_range(1, 3));
            else nh = 0;
            for (int h = 0; h < nh; h++) begin
               r       = blank_vec();
               r.busy  = 1'b1;
               r.hold  = 1'b1;
               r.stage = s;
               r.start = pick_start(mode);
               trace.push_back(r);
               hold_total++;
            end
            r          = blank_vec();
            r.busy     = 1'b1;
            r.bf_issue = 1'b1;
            r.stage    = s;
            r.k        = k;
            r.addr_a   = (k / half) * 2 * half + (k % half);
            r.addr_b   = r.addr_a + half;
            r.tw       = (k % half) * (N / (2 * half));
            r.start    = pick_start(mode);
            trace.push_back(r);
         end
         for (int d = 0; d < BF_LAT; d++) begin
            r       = blank_vec();
            r.busy  = 1'b1;
            r.hold  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            r.start = pick_start(mode);
            trace.push_back(r);
         end
      end
      r       = blank_vec();
      r.busy  = 1'b1;
      r.done  = 1'b1;
      r.start = (mode == 1) || pick_start(mode);
      trace.push_back(r);
      r = blank_vec();
      trace.push_back(r);
   endtask

   task automatic run_trace(input string tag, input int expect_done);
      vec_t r;
      logic wb_exp;
      int   wa;
      int   wbb;
      int   done_at;
      int   done_cnt;
      int   slot;
      apply_stimulus(1'b1, 1'b0);
      check_output({tag, " start idle"}, 0, {31'b0, busy}, 32'h0);
      done_at  = -1;
      done_cnt = 0;
      for (int idx = 0; idx < trace.size(); idx++) begin
         r = trace[idx];
         apply_stimulus(r.start, r.hold);
         if (idx >= BF_LAT) begin
            wb_exp = trace[idx-BF_LAT].bf_issue;
            wa     = trace[idx-BF_LAT].addr_a;
            wbb    = trace[idx-BF_LAT].addr_b;
         end else begin
            wb_exp = 1'b0;
            wa     = 0;
            wbb    = 0;
         end
         check_output({tag, " ctrl"}, idx + 1,
                      {27'b0, busy, done, load_en, bf_issue, wb_en},
                      {27'b0, r.busy, r.done, r.load_en, r.bf_issue, wb_exp});
         if (r.load_en) begin
            check_output({tag, " load"}, idx + 1,
                         (32'(load_src) << 8) | 32'(load_addr),
                         32'((r.load_src << 8) | r.load_addr));
            obs_load[r.load_src] = int'(load_addr);
         end
         if (r.bf_issue) begin
            check_output({tag, " pair"}, idx + 1,
                         (32'(addr_a) << 16) | (32'(addr_b) << 8) | 32'(tw_idx),
                         32'((r.addr_a << 16) | (r.addr_b << 8) | r.tw));
            slot         = r.stage * HALF_N + r.k;
            obs_a[slot]  = int'(addr_a);
            obs_b[slot]  = int'(addr_b);
            obs_tw[slot] = int'(tw_idx);
         end
         if (r.stage >= 0) begin
            check_output({tag, " stage"}, idx + 1, 32'(stage), 32'(r.stage));
         end
         if (wb_exp) begin
            check_output({tag, " wb addr"}, idx + 1,
                         (32'(wb_addr_a) << 8) | 32'(wb_addr_b),
                         32'((wa << 8) | wbb));
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = idx + 1;
         end
      end
      check_output({tag, " done cycle"}, 0, 32'(done_at), 32'(expect_done));
      check_output({tag, " done pulses"}, 0, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int busy_cnt;
      int done_cnt;
      int slot;

      known[0] = '{0, 0, 0, 1, 0};
      known[1] = '{0, 3, 6, 7, 0};
      known[2] = '{1, 1, 1, 3, 16};
      known[3] = '{2, 5, 9, 13, 8};
      known[4] = '{5, 1, 1, 33, 1};
      known[5] = '{5, 31, 31, 63, 31};
`ifdef FFT_SEQ_BITREV_EN
      known_load = '{0, 32, 16, 48};
`else
      known_load = '{0, 1, 2, 3};
`endif
      for (int i = 0; i < LOG2_N * HALF_N; i++) begin
         obs_a[i]  = -1;
         obs_b[i]  = -1;
         obs_tw[i] = -1;
      end
      for (int i = 0; i < N; i++) obs_load[i] = -1;

      rst   = 1'b0;
      start = 1'b0;
      hold  = 1'b0;
      repeat (3) apply_stimulus(1'b0, 1'b0);
      check_reset_values("reset");
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0);
      check_reset_values("idle after reset");

      $display("[TB] run A: plain transform");
      build_trace(0);
      run_trace("runA", 269);

      for (int i = 0; i < 6; i++) begin
         slot = known[i].s * HALF_N + known[i].k;
         check_output($sformatf("known bf s%0d k%0d", known[i].s, known[i].k), i,
                      32'((obs_a[slot] << 16) | (obs_b[slot] << 8) | obs_tw[slot]),
                      32'((known[i].a << 16) | (known[i].b << 8) | known[i].tw));
      end
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("known load %0d", i), i,
                      32'(obs_load[i]), 32'(known_load[i]));
      end

      $display("[TB] run B: 5 hold cycles in stage 2, stray starts");
      build_trace(1);
      run_trace("runB", 274);

      $display("[TB] mid-transform reset");
      apply_stimulus(1'b1, 1'b0);
      repeat (100) apply_stimulus(1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_reset_values("async reset");
      @(posedge clk);
      #1 rst = 1'b1;
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(1'b0, 1'b0);
         if (busy !== 1'b0) busy_cnt++;
         if (done !== 1'b0) done_cnt++;
      end
      check_output("post reset busy", 0, 32'(busy_cnt), 32'd0);
      check_output("post reset done", 0, 32'(done_cnt), 32'd0);

      $display("[TB] run C: random hold and start");
      build_trace(2);
      run_trace("runC", N + LOG2_N * (HALF_N + BF_LAT) + 1 + hold_total);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
